setup_move_sequencer: RTL and testbench

SETUP_MOVE_SEQUENCER -- requirements
Module: setup_move_sequencer

---
 rtl/cube_pkg.sv | 87 ++++++++
 rtl/setup_move_rom.sv | 48 ++++
 rtl/setup_move_sequencer.sv | 128 ++++++++++++
 tb/tb_setup_move_sequencer.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cube_pkg.sv
// Shared cube encodings and the per-batch setup move table for the sticker-observation sequencer.
package cube_pkg;

   typedef enum logic [2:0] {
      FACE_U = 3'd0,
      FACE_L = 3'd1,
      FACE_F = 3'd2,
      FACE_R = 3'd3,
      FACE_B = 3'd4,
      FACE_D = 3'd5
   } face_t;

   typedef enum logic [1:0] {
      TURN_NONE = 2'd0,
      TURN_CW   = 2'd1,
      TURN_180  = 2'd2,
      TURN_CCW  = 2'd3
   } turn_t;

   typedef enum logic [2:0] {
      COLOR_W = 3'd0,
      COLOR_O = 3'd1,
      COLOR_G = 3'd2,
      COLOR_R = 3'd3,
      COLOR_B = 3'd4,
      COLOR_Y = 3'd5
   } color_t;

   typedef struct packed {
      face_t face;
      turn_t turn;
   } move_t;

   // Setup for one 4-sticker batch: up to two moves, m0 played first.
   typedef struct packed {
      logic [3:0] len;
      move_t      m0;
      move_t      m1;
   } setup_t;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FETCH,
      ST_ISSUE,
      ST_WAIT_MOTOR,
      ST_DONE
   } seq_state_t;

   localparam int NUM_STEPS       = 48;
   localparam int STEPS_PER_BATCH = 4;

   function automatic move_t mk_move(input face_t f, input turn_t t);
      move_t m;
      m.face = f;
      m.turn = t;
      return m;
   endfunction

   // Inverse of a quarter/half turn is its negation modulo four.
   function automatic move_t invert_move(input move_t m);
      move_t r;
      r      = m;
      r.turn = turn_t'(2'd0 - m.turn);
      return r;
   endfunction

   function automatic setup_t batch_setup(input logic [3:0] batch);
      setup_t s;
      s = '0;
      case (batch)
         4'd1:    s = '{4'd2, mk_move(FACE_F, TURN_CW),  mk_move(FACE_B, TURN_CCW)};
         4'd2:    s = '{4'd2, mk_move(FACE_R, TURN_CW),  mk_move(FACE_L, TURN_CCW)};
         4'd3:    s = '{4'd2, mk_move(FACE_F, TURN_180), mk_move(FACE_B, TURN_180)};
         4'd4:    s = '{4'd2, mk_move(FACE_R, TURN_180), mk_move(FACE_L, TURN_180)};
         4'd5:    s = '{4'd2, mk_move(FACE_F, TURN_CCW), mk_move(FACE_B, TURN_CW)};
         4'd6:    s = '{4'd2, mk_move(FACE_R, TURN_CCW), mk_move(FACE_L, TURN_CW)};
         4'd7:    s = '{4'd1, mk_move(FACE_D, TURN_CW),  move_t'('0)};
         4'd8:    s = '{4'd1, mk_move(FACE_D, TURN_180), move_t'('0)};
         4'd9:    s = '{4'd1, mk_move(FACE_D, TURN_CCW), move_t'('0)};
         4'd10:   s = '{4'd2, mk_move(FACE_F, TURN_CW),  mk_move(FACE_R, TURN_CW)};
         4'd11:   s = '{4'd2, mk_move(FACE_R, TURN_CCW), mk_move(FACE_F, TURN_CCW)};
         default: s = '0;
      endcase
      return s;
   endfunction

endpackage

// File: rtl/setup_move_rom.sv
// Combinational setup-move table: undo of the previous batch then the next batch's setup at each
// batch's first step, a single U at the other steps, nothing at step 0.
module setup_move_rom
   import cube_pkg::*;
(
   input  logic [5:0] step,
   input  logic [3:0] mv_idx,
   output logic [4:0] move,
   output logic       valid,
   output logic       last
);

   logic [3:0] w_batch;
   setup_t     w_prev;
   setup_t     w_cur;
   logic [3:0] w_total;
   logic [3:0] w_rel;

   assign w_batch = step[5:2];
   assign w_prev  = batch_setup(w_batch - 4'd1);
   assign w_cur   = batch_setup(w_batch);
   assign w_total = w_prev.len + w_cur.len;
   assign w_rel   = mv_idx - w_prev.len;

   // NOTE: every output gets a default before the branches so no path can infer a latch.
   always_comb begin
      move  = '0;
      valid = 1'b0;
      last  = 1'b0;
      if (step != 6'd0) begin
         if (step[1:0] != 2'd0) begin
            move  = mk_move(FACE_U, TURN_CW);
            valid = (mv_idx == 4'd0);
            last  = (mv_idx == 4'd0);
         end else if (mv_idx < w_prev.len) begin
            // Undo walks the previous setup backwards.
            move  = invert_move((mv_idx == w_prev.len - 4'd1) ? w_prev.m0 : w_prev.m1);
            valid = 1'b1;
            last  = (mv_idx == w_total - 4'd1);
         end else if (mv_idx < w_total) begin
            move  = (w_rel == 4'd0) ? w_cur.m0 : w_cur.m1;
            valid = 1'b1;
            last  = (mv_idx == w_total - 4'd1);
         end
      end
   end

endmodule

// File: rtl/setup_move_sequencer.sv
// Plays the setup moves for each sticker observation step through a valid/ready motor interface.
// Optional motor watchdog enabled by defining STEP_TIMEOUT_EN.
module setup_move_sequencer
   import cube_pkg::*;
#(
   parameter logic [23:0] MOTOR_TIMEOUT = 24'd10_000_000
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       send_setup_moves,
   output logic [4:0] move,
   output logic       move_valid,
   input  logic       move_ready,
   input  logic       motor_done,
   output logic       done_turning,
   output logic [5:0] step,
   output logic       busy,
   output logic       seq_complete,
   output logic       error
);

   localparam logic [5:0] LAST_STEP = 6'(NUM_STEPS - 1);

   seq_state_t r_state;
   seq_state_t w_next_state;
   logic [5:0] r_step;
   logic [3:0] r_mv_idx;
   logic [4:0] r_move;
   logic       r_last;
   logic       r_motor_done;
   logic [4:0] w_rom_move;
   logic       w_rom_valid;
   logic       w_rom_last;
   logic       w_start_ok;
   logic       w_timeout;

   setup_move_rom u_rom (
      .step   (r_step),
      .mv_idx (r_mv_idx),
      .move   (w_rom_move),
      .valid  (w_rom_valid),
      .last   (w_rom_last)
   );

`ifdef STEP_TIMEOUT_EN
   logic [23:0] r_timer;
   logic        r_error;

   assign w_timeout  = (r_state == ST_WAIT_MOTOR) && (r_timer == MOTOR_TIMEOUT - 24'd1);
   assign w_start_ok = send_setup_moves && !r_error;
   assign error      = r_error;

   always_ff @(posedge clock) begin
      if (reset) begin
         r_timer <= '0;
         r_error <= 1'b0;
      end else begin
         r_timer <= (r_state == ST_WAIT_MOTOR) ? r_timer + 24'd1 : 24'd0;
         if (w_timeout && !r_motor_done) begin
            r_error <= 1'b1;
         end
      end
   end
`else
   assign w_timeout  = 1'b0;
   assign w_start_ok = send_setup_moves;
   // The limit only matters when the watchdog is built in.
   assign error      = 1'b0 & (|MOTOR_TIMEOUT);
`endif

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         ST_IDLE:       if (w_start_ok) w_next_state = ST_FETCH;
         ST_FETCH:      w_next_state = w_rom_valid ? ST_ISSUE : ST_DONE;
         ST_ISSUE:      if (move_ready) w_next_state = ST_WAIT_MOTOR;
         ST_WAIT_MOTOR: begin
            if (r_motor_done) begin
               w_next_state = r_last ? ST_DONE : ST_FETCH;
            end else if (w_timeout) begin
               w_next_state = ST_IDLE;
            end
         end
         ST_DONE:       w_next_state = ST_IDLE;
         default:       w_next_state = ST_IDLE;
      endcase
   end

   // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_state      <= ST_IDLE;
         r_step       <= '0;
         r_mv_idx     <= '0;
         r_move       <= '0;
         r_last       <= 1'b0;
         r_motor_done <= 1'b0;
      end else begin
         r_state      <= w_next_state;
         // Motor pulse is registered and only accepted while a move is actually in flight.
         r_motor_done <= motor_done && (r_state == ST_WAIT_MOTOR);
         case (r_state)
            ST_IDLE:  r_mv_idx <= '0;
            ST_FETCH: begin
               if (w_rom_valid) begin
                  r_move <= w_rom_move;
                  r_last <= w_rom_last;
               end
            end
            ST_WAIT_MOTOR: begin
               if (r_motor_done && !r_last) begin
                  r_mv_idx <= r_mv_idx + 4'd1;
               end
            end
            ST_DONE:  r_step <= (r_step == LAST_STEP) ? 6'd0 : r_step + 6'd1;
            default:  ;
         endcase
      end
   end

   assign move         = r_move;
   assign move_valid   = (r_state == ST_ISSUE);
   assign busy         = (r_state != ST_IDLE);
   assign done_turning = (r_state == ST_DONE);
   assign seq_complete = (r_state == ST_DONE) && (r_step == LAST_STEP);
   assign step         = r_step;

endmodule

// File: tb/tb_setup_move_sequencer.sv
// Randomized bench for setup_move_sequencer against a move-list model of the observation sequence.
// The watchdog scenario runs only when STEP_TIMEOUT_EN is defined.
module tb_setup_move_sequencer;

`ifdef STEP_TIMEOUT_EN
   localparam logic [23:0] TB_TIMEOUT = 24'd100;
`else
   localparam logic [23:0] TB_TIMEOUT = 24'd10_000_000;
`endif

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       send_setup_moves = 1'b0;
   logic       move_ready = 1'b0;
   logic       motor_done = 1'b0;
   logic [4:0] move;
   logic       move_valid;
   logic       done_turning;
   logic [5:0] step;
   logic       busy;
   logic       seq_complete;
   logic       error;

   int         checks = 0;
   int         errors = 0;
   int         exp_step = 0;
   logic [4:0] exp_q[$];
   logic [4:0] setup_tbl [12][2];
   int         setup_n [12];

   setup_move_sequencer #(.MOTOR_TIMEOUT(TB_TIMEOUT)) dut (
      .clock            (clock),
      .reset            (reset),
      .send_setup_moves (send_setup_moves),
      .move             (move),
      .move_valid       (move_valid),
      .move_ready       (move_ready),
      .motor_done       (motor_done),
      .done_turning     (done_turning),
      .step             (step),
      .busy             (busy),
      .seq_complete     (seq_complete),
      .error            (error)
   );

   always #5 clock = ~clock;

   initial begin
      #400_000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   function automatic logic [4:0] mk(input int face, input int turn);
      return {3'(face), 2'(turn)};
   endfunction

   // Batch setups: U=0 L=1 F=2 R=3 B=4 D=5; CW=1 180=2 CCW=3.
   function automatic void init_tables();
      for (int b = 0; b < 12; b++) begin
         setup_tbl[b][0] = '0;
         setup_tbl[b][1] = '0;
      end
      setup_n = '{0, 2, 2, 2, 2, 2, 2, 1, 1, 1, 2, 2};
      setup_tbl[1]  = '{mk(2, 1), mk(4, 3)};
      setup_tbl[2]  = '{mk(3, 1), mk(1, 3)};
      setup_tbl[3]  = '{mk(2, 2), mk(4, 2)};
      setup_tbl[4]  = '{mk(3, 2), mk(1, 2)};
      setup_tbl[5]  = '{mk(2, 3), mk(4, 1)};
      setup_tbl[6]  = '{mk(3, 3), mk(1, 1)};
      setup_tbl[7][0]  = mk(5, 1);
      setup_tbl[8][0]  = mk(5, 2);
      setup_tbl[9][0]  = mk(5, 3);
      setup_tbl[10] = '{mk(2, 1), mk(3, 1)};
      setup_tbl[11] = '{mk(3, 3), mk(2, 3)};
   endfunction

   function automatic void build_expected(input int s);
      int k;
      logic [4:0] m;
      exp_q.delete();
      if (s == 0) return;
      if (s % 4 != 0) begin
         exp_q.push_back(mk(0, 1));
         return;
      end
      k = s / 4;
      for (int i = setup_n[k-1] - 1; i >= 0; i--) begin
         m = setup_tbl[k-1][i];
         exp_q.push_back({m[4:2], 2'(4 - int'(m[1:0]))});
      end
      for (int i = 0; i < setup_n[k]; i++) exp_q.push_back(setup_tbl[k][i]);
   endfunction

   // Requests one step and plays motor driver until done_turning, checking moves and timing.
   task automatic run_step(input int ready_lat, input int motor_lat, input bit sly);
      int s, idx, wait_rdy, vcnt, motor_cnt, motor_k, total_valid;
      bit done_seen;
      s = exp_step;
      build_expected(s);
      idx = 0; wait_rdy = 0; vcnt = 0; motor_cnt = -1; motor_k = -100;
      total_valid = 0; done_seen = 1'b0;
      for (int k = 0; k < 600 && !done_seen; k++) begin
         @(negedge clock);
         if (done_turning) begin
            done_seen = 1'b1;
            chk($sformatf("done_latency_s%0d", s), k, (exp_q.size() == 0) ? 2 : motor_k + 2);
            chk($sformatf("moves_issued_s%0d", s), idx, exp_q.size());
            chk($sformatf("seq_complete_s%0d", s), seq_complete, s == 47);
            chk("busy_in_done", busy, 1);
         end else begin
            if (seq_complete) chk("seq_without_done", seq_complete, 0);
            if (k >= 1) chk($sformatf("busy_s%0d", s), busy, 1);
         end
         if (move_valid) begin
            total_valid++;
            vcnt++;
            if (idx < exp_q.size()) chk($sformatf("move_s%0d_i%0d", s, idx), move, exp_q[idx]);
            else chk($sformatf("extra_move_s%0d", s), idx, exp_q.size() - 1);
         end
         send_setup_moves = (k == 0);
         motor_done = 1'b0;
         move_ready = 1'b0;
         if (move_valid && !done_seen) begin
            if (wait_rdy >= ready_lat) begin
               move_ready = 1'b1;
               chk($sformatf("valid_hold_s%0d", s), vcnt, ready_lat + 1);
               idx++; vcnt = 0; wait_rdy = 0;
               motor_cnt = motor_lat;
               if (sly) motor_done = 1'b1;
            end else begin
               wait_rdy++;
            end
         end else if (motor_cnt > 0) begin
            motor_cnt--;
            if (sly) send_setup_moves = 1'b1;
         end else if (motor_cnt == 0) begin
            motor_done = 1'b1;
            motor_k = k;
            motor_cnt = -1;
         end
      end
      chk($sformatf("done_seen_s%0d", s), done_seen, 1);
      chk($sformatf("valid_cycles_s%0d", s), total_valid, exp_q.size() * (ready_lat + 1));
      send_setup_moves = 1'b0;
      motor_done = 1'b0;
      move_ready = 1'b0;
      exp_step = (s + 1) % 48;
      @(negedge clock);
      chk("idle_busy", busy, 0);
      chk("idle_done", done_turning, 0);
      chk($sformatf("step_after_s%0d", s), step, exp_step);
      motor_done = 1'b1;
      @(negedge clock);
      motor_done = 1'b0;
      chk("stray_motor_busy", busy, 0);
      chk("stray_motor_done", done_turning, 0);
      chk("stray_motor_step", step, exp_step);
   endtask

   initial begin
      init_tables();
      reset = 1'b1;
      repeat (3) @(negedge clock);
      chk("rst_move", move, 0);
      chk("rst_valid", move_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done_turning, 0);
      chk("rst_seq", seq_complete, 0);
      chk("rst_step", step, 0);
      chk("rst_error", error, 0);
      reset = 1'b0;
      exp_step = 0;

      run_step(0, 3, 1'b0);
      run_step(0, 5, 1'b0);
      run_step($urandom_range(0, 2), $urandom_range(0, 4), 1'b0);
      run_step($urandom_range(0, 2), $urandom_range(0, 4), 1'b0);
      run_step(10, 2, 1'b0);
      for (int i = 5; i < 48; i++) begin
         run_step($urandom_range(0, 3), $urandom_range(0, 6), $urandom_range(0, 1) == 1);
      end
      chk("wrapped_step", step, 0);

      // Abort in the middle of step 4 while a move is presented.
      for (int i = 0; i < 4; i++) run_step($urandom_range(0, 2), $urandom_range(0, 3), 1'b1);
      @(negedge clock);
      send_setup_moves = 1'b1;
      @(negedge clock);
      send_setup_moves = 1'b0;
      for (int n = 0; n < 10 && !move_valid; n++) @(negedge clock);
      chk("valid_before_reset", move_valid, 1);
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      chk("abort_valid", move_valid, 0);
      chk("abort_busy", busy, 0);
      chk("abort_step", step, 0);
      chk("abort_move", move, 0);
      for (int n = 0; n < 4; n++) begin
         @(negedge clock);
         chk("abort_no_done", done_turning, 0);
      end
      exp_step = 0;

`ifdef STEP_TIMEOUT_EN
      begin
         int wc;
         run_step(0, 1, 1'b0);
         @(negedge clock);
         send_setup_moves = 1'b1;
         @(negedge clock);
         send_setup_moves = 1'b0;
         for (int n = 0; n < 10 && !move_valid; n++) @(negedge clock);
         chk("to_valid", move_valid, 1);
         move_ready = 1'b1;
         wc = 0;
         for (int n = 0; n < 300; n++) begin
            @(negedge clock);
            move_ready = 1'b0;
            if (error) break;
            wc++;
         end
         chk("to_wait_cycles", wc, 100);
         chk("to_error", error, 1);
         chk("to_busy", busy, 0);
         chk("to_step", step, 1);
         send_setup_moves = 1'b1;
         @(negedge clock);
         send_setup_moves = 1'b0;
         @(negedge clock);
         chk("to_send_ignored", busy, 0);
         chk("to_error_sticky", error, 1);
         reset = 1'b1;
         @(negedge clock);
         reset = 1'b0;
         chk("to_reset_clears", error, 0);
      end
`endif

      chk("final_error", error, 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
